// File: rtl/mssd_pkg.sv
// Shared definitions for the MSSD serial transmitter.
// Build option: define MSSD_TX_PARITY_EN to append an even-parity bit
// after the payload (the receiver build must agree).
package mssd_pkg;

    localparam int PORT_W = 2;
    localparam int CNT_W  = 4;

    // Transmitter controller states (exposed on state_dbg).
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_PORT  = 3'd2,
        S_CNT   = 3'd3,
        S_DATA  = 3'd4,
        S_PAR   = 3'd5
    } tx_state_t;

    // Datapath commands issued by the controller each clock.
    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_LOAD       = 3'd1,
        OP_PORT_FIRST = 3'd2,
        OP_PORT       = 3'd3,
        OP_LEN_FIRST  = 3'd4,
        OP_LEN        = 3'd5,
        OP_DATA_FIRST = 3'd6,
        OP_DATA       = 3'd7
    } dp_op_t;

    // Frame length in bit periods for a given payload length.
    function automatic int frame_bits(input int len, input bit par_en);
        return 1 + PORT_W + CNT_W + len + (par_en ? 1 : 0);
    endfunction

endpackage

// File: rtl/mssd_tx_datapath.sv
// Shift registers, bit counter and parity accumulator for mssd_tx.
// The *_bit outputs always present the next bit of each field to send.
// Build option MSSD_TX_PARITY_EN adds the parity accumulator and par_bit.
module mssd_tx_datapath #(
    parameter int PORT_W = mssd_pkg::PORT_W,
    parameter int CNT_W  = mssd_pkg::CNT_W,
    parameter int DATA_W = 2**CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        op,
    input  logic [PORT_W-1:0] port,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] data,
    output logic              port_bit,
    output logic              len_bit,
    output logic              data_bit,
`ifdef MSSD_TX_PARITY_EN
    output logic              par_bit,
`endif
    output logic              cnt_zero,
    output logic              len_zero
);
    import mssd_pkg::*;

    logic [PORT_W-1:0] port_sr;
    logic [CNT_W-1:0]  len_sr;
    logic [CNT_W-1:0]  len_q;
    logic [DATA_W-1:0] data_sr;
    logic [CNT_W-1:0]  cnt;

    assign port_bit = port_sr[PORT_W-1];
    assign len_bit  = len_sr[CNT_W-1];
    assign data_bit = data_sr[0];
    assign cnt_zero = (cnt == '0);
    assign len_zero = (len_q == '0);

    // Field shifters and bit counter; port/len go MSB first, data LSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            port_sr <= '0;
            len_sr  <= '0;
            len_q   <= '0;
            data_sr <= '0;
            cnt     <= '0;
        end else begin
            case (dp_op_t'(op))
                OP_LOAD: begin
                    port_sr <= port;
                    len_sr  <= len;
                    len_q   <= len;
                    data_sr <= data;
                    cnt     <= '0;
                end
                OP_PORT_FIRST: begin
                    port_sr <= port_sr << 1;
                    cnt     <= CNT_W'(PORT_W - 1);
                end
                OP_PORT: begin
                    port_sr <= port_sr << 1;
                    cnt     <= cnt - 1'b1;
                end
                OP_LEN_FIRST: begin
                    len_sr <= len_sr << 1;
                    cnt    <= CNT_W'(CNT_W - 1);
                end
                OP_LEN: begin
                    len_sr <= len_sr << 1;
                    cnt    <= cnt - 1'b1;
                end
                OP_DATA_FIRST: begin
                    data_sr <= data_sr >> 1;
                    cnt     <= len_q - 1'b1;
                end
                OP_DATA: begin
                    data_sr <= data_sr >> 1;
                    cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef MSSD_TX_PARITY_EN
    logic par;
    assign par_bit = par;

    // Even parity over the data bits as each one is put on the line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else if (dp_op_t'(op) == OP_LOAD) begin
            par <= 1'b0;
        end else if (dp_op_t'(op) == OP_DATA_FIRST || dp_op_t'(op) == OP_DATA) begin
            par <= par ^ data_sr[0];
        end
    end
`endif

endmodule

// File: rtl/mssd_tx.sv
// MSSD serial frame transmitter: start bit, port (MSB first), len (MSB
// first), len data bits (LSB first), optional parity, then idle high.
// Build option: MSSD_TX_PARITY_EN adds the even-parity bit period.
// Handshake: a request is taken on any clk edge where start && ready;
// ready is high only in IDLE, so start while busy is ignored.
module mssd_tx #(
    parameter int PORT_W = mssd_pkg::PORT_W,
    parameter int CNT_W  = mssd_pkg::CNT_W,
    parameter int DATA_W = 2**CNT_W - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              start,
    input  logic [PORT_W-1:0] port,
    input  logic [CNT_W-1:0]  len,
    input  logic [DATA_W-1:0] data,
    output logic              SerOut,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);
    import mssd_pkg::*;

    tx_state_t state;
    dp_op_t    op;
    logic      frame_end;
    logic      port_bit, len_bit, data_bit, cnt_zero, len_zero;
`ifdef MSSD_TX_PARITY_EN
    logic      par_bit;
`endif

    assign state_dbg = state;

    mssd_tx_datapath #(
        .PORT_W (PORT_W),
        .CNT_W  (CNT_W),
        .DATA_W (DATA_W)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .port     (port),
        .len      (len),
        .data     (data),
        .port_bit (port_bit),
        .len_bit  (len_bit),
        .data_bit (data_bit),
`ifdef MSSD_TX_PARITY_EN
        .par_bit  (par_bit),
`endif
        .cnt_zero (cnt_zero),
        .len_zero (len_zero)
    );

    // Decode the datapath command and the last-bit-period condition.
    always_comb begin
        op        = OP_HOLD;
        frame_end = 1'b0;
        case (state)
            S_IDLE:  if (start && ready) op = OP_LOAD;
            S_START: if (clk_en) op = OP_PORT_FIRST;
            S_PORT: if (clk_en) begin
                if (cnt_zero) op = OP_LEN_FIRST;
                else          op = OP_PORT;
            end
            S_CNT: if (clk_en) begin
                if (!cnt_zero)      op = OP_LEN;
                else if (!len_zero) op = OP_DATA_FIRST;
`ifndef MSSD_TX_PARITY_EN
                else                frame_end = 1'b1;
`endif
            end
            S_DATA: if (clk_en) begin
                if (!cnt_zero) op = OP_DATA;
`ifndef MSSD_TX_PARITY_EN
                else           frame_end = 1'b1;
`endif
            end
`ifdef MSSD_TX_PARITY_EN
            S_PAR: frame_end = clk_en;
`endif
            default: ;
        endcase
    end

    // Controller FSM with registered line and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            SerOut <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (frame_end) begin
                state  <= S_IDLE;
                SerOut <= 1'b1;
                done   <= 1'b1;
                ready  <= 1'b1;
                busy   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: if (start && ready) begin
                        state  <= S_START;
                        SerOut <= 1'b0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                    end
                    S_START: if (clk_en) begin
                        state  <= S_PORT;
                        SerOut <= port_bit;
                    end
                    S_PORT: if (clk_en) begin
                        if (cnt_zero) begin
                            state  <= S_CNT;
                            SerOut <= len_bit;
                        end else begin
                            SerOut <= port_bit;
                        end
                    end
                    S_CNT: if (clk_en) begin
                        if (!cnt_zero) begin
                            SerOut <= len_bit;
                        end else if (!len_zero) begin
                            state  <= S_DATA;
                            SerOut <= data_bit;
                        end
`ifdef MSSD_TX_PARITY_EN
                        else begin
                            state  <= S_PAR;
                            SerOut <= par_bit;
                        end
`endif
                    end
                    S_DATA: if (clk_en) begin
                        if (!cnt_zero) begin
                            SerOut <= data_bit;
                        end
`ifdef MSSD_TX_PARITY_EN
                        else begin
                            state  <= S_PAR;
                            SerOut <= par_bit;
                        end
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
